// File: rtl/isol_bridge.sv
// Multi-channel isolation bridge between the M1 and M2 domains. Pipelines strobe and data words per channel.
// Drains the pipeline and clamps the outputs to zero while isolated, then resumes after a settle period.
module isol_bridge #(
    parameter int NCH        = 2,
    parameter int DW         = 8,
    parameter int STAGES     = 1,
    parameter int RESUME_CYC = 2
) (
    input  logic                ck,
    input  logic                arst_n,
    input  logic                isolate,
    input  logic [NCH-1:0]      src_ready,
    input  logic [NCH*DW-1:0]   src_data,
    output logic [NCH-1:0]      dst_execute,
    output logic [NCH*DW-1:0]   dst_data,
    output logic [1:0]          iso_state,
    output logic                iso_ack,
    output logic [15:0]         drop_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        ISO    = 2'd2,
        RESUME = 2'd3
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                gate;
    logic [NCH-1:0]      rdy_pipe [STAGES];
    logic [NCH*DW-1:0]   dat_pipe [STAGES];

    // Gating is combinational so the very cycle isolate rises is already blocked.
    assign gate = (state != RUN) | isolate;

    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                rdy_pipe[s] <= '0;
                dat_pipe[s] <= '0;
            end
        end else begin
            rdy_pipe[0] <= src_ready & ~{NCH{gate}};
            dat_pipe[0] <= src_data & ~{(NCH*DW){gate}};
            for (int s = 1; s < STAGES; s++) begin
                rdy_pipe[s] <= rdy_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign dst_execute = rdy_pipe[STAGES-1];
    assign dst_data    = dat_pipe[STAGES-1];

    // One counter serves both the drain length and the resume settle time.
    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            state   <= RUN;
            cnt     <= '0;
            iso_ack <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (isolate) begin
                        state <= DRAIN;
                        cnt   <= 4'(STAGES);
                    end
                end
                DRAIN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state   <= ISO;
                        iso_ack <= 1'b1;
                    end
                end
                ISO: begin
                    if (!isolate) begin
                        state   <= RESUME;
                        cnt     <= 4'(RESUME_CYC);
                        iso_ack <= 1'b0;
                    end
                end
                RESUME: begin
                    if (isolate) begin
                        state   <= ISO;
                        cnt     <= '0;
                        iso_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state   <= RUN;
                    cnt     <= '0;
                    iso_ack <= 1'b0;
                end
            endcase
        end
    end

    assign iso_state = state;

    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            drop_cnt <= '0;
        end else if (gate && (|src_ready) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_isol_bridge.sv
// Self-checking bench for isol_bridge: vector table with a datapath scoreboard queue,
// plus hand-written reset, mid-drain reset and counter saturation sequences.
module tb_isol_bridge;

    localparam int NCH        = 2;
    localparam int DW         = 8;
    localparam int STAGES     = 2;
    localparam int RESUME_CYC = 3;

    logic                ck;
    logic                arst_n;
    logic                isolate;
    logic [NCH-1:0]      src_ready;
    logic [NCH*DW-1:0]   src_data;
    logic [NCH-1:0]      dst_execute;
    logic [NCH*DW-1:0]   dst_data;
    logic [1:0]          iso_state;
    logic                iso_ack;
    logic [15:0]         drop_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic                iso;
        logic [NCH-1:0]      rdy;
        logic [NCH*DW-1:0]   dat;
        logic                gated;
        logic [1:0]          st;
    } vec_t;

    vec_t                      vecs [30];
    logic [NCH+NCH*DW-1:0]     exp_q [$];
    logic [15:0]               exp_drop;

    isol_bridge #(
        .NCH(NCH), .DW(DW), .STAGES(STAGES), .RESUME_CYC(RESUME_CYC)
    ) dut (
        .ck(ck),
        .arst_n(arst_n),
        .isolate(isolate),
        .src_ready(src_ready),
        .src_data(src_data),
        .dst_execute(dst_execute),
        .dst_data(dst_data),
        .iso_state(iso_state),
        .iso_ack(iso_ack),
        .drop_cnt(drop_cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle, records the expected pipeline output and compares the word leaving the pipe.
    task automatic applyStimulus(input string tag, input logic iso, input logic [NCH-1:0] rdy,
                                 input logic [NCH*DW-1:0] dat, input logic gated_exp);
        logic [NCH+NCH*DW-1:0] exp_word;
        isolate   = iso;
        src_ready = rdy;
        src_data  = dat;
        exp_q.push_back(gated_exp ? '0 : {rdy, dat});
        if (gated_exp && (|rdy) && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        step();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: queue empty", tag);
        end else begin
            exp_word = exp_q.pop_front();
            checkOutput({tag, " dst_execute"}, 32'(dst_execute), 32'(exp_word[NCH+NCH*DW-1:NCH*DW]));
            checkOutput({tag, " dst_data"}, 32'(dst_data), 32'(exp_word[NCH*DW-1:0]));
        end
        checkOutput({tag, " drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    task automatic prime_queue();
        exp_q.delete();
        for (int i = 0; i < STAGES - 1; i++) exp_q.push_back('0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'b01, 16'h0001, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 2'b00, 16'h0002, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 2'b01, 16'h0003, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 2'b01, 16'h0004, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 2'b00, 16'h0000, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 2'b01, 16'h0011, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 2'b01, 16'h0012, 1'b0, 2'd0};
        vecs[7]  = '{1'b1, 2'b01, 16'h0013, 1'b1, 2'd1};
        vecs[8]  = '{1'b0, 2'b01, 16'h0014, 1'b1, 2'd1};
        vecs[9]  = '{1'b1, 2'b01, 16'h0015, 1'b1, 2'd2};
        vecs[10] = '{1'b1, 2'b01, 16'h0016, 1'b1, 2'd2};
        vecs[11] = '{1'b0, 2'b01, 16'h0017, 1'b1, 2'd3};
        vecs[12] = '{1'b0, 2'b01, 16'h0018, 1'b1, 2'd3};
        vecs[13] = '{1'b0, 2'b01, 16'h0019, 1'b1, 2'd3};
        vecs[14] = '{1'b0, 2'b01, 16'h001A, 1'b1, 2'd0};
        vecs[15] = '{1'b0, 2'b01, 16'h0021, 1'b0, 2'd0};
        vecs[16] = '{1'b0, 2'b10, 16'h2200, 1'b0, 2'd0};
        vecs[17] = '{1'b1, 2'b11, 16'h3333, 1'b1, 2'd1};
        vecs[18] = '{1'b1, 2'b11, 16'h3434, 1'b1, 2'd1};
        vecs[19] = '{1'b1, 2'b11, 16'h3535, 1'b1, 2'd2};
        vecs[20] = '{1'b0, 2'b11, 16'h3636, 1'b1, 2'd3};
        vecs[21] = '{1'b0, 2'b11, 16'h3737, 1'b1, 2'd3};
        vecs[22] = '{1'b1, 2'b11, 16'h3838, 1'b1, 2'd2};
        vecs[23] = '{1'b0, 2'b11, 16'h3939, 1'b1, 2'd3};
        vecs[24] = '{1'b0, 2'b11, 16'h4040, 1'b1, 2'd3};
        vecs[25] = '{1'b0, 2'b11, 16'h4141, 1'b1, 2'd3};
        vecs[26] = '{1'b0, 2'b11, 16'h4242, 1'b1, 2'd0};
        vecs[27] = '{1'b0, 2'b11, 16'hBEEF, 1'b0, 2'd0};
        vecs[28] = '{1'b0, 2'b00, 16'h0000, 1'b0, 2'd0};
        vecs[29] = '{1'b0, 2'b00, 16'h0000, 1'b0, 2'd0};

        // Reset with live-looking inputs: everything must stay at zero.
        arst_n    = 1'b0;
        isolate   = 1'b0;
        src_ready = 2'b11;
        src_data  = 16'hA55A;
        exp_drop  = '0;
        #25;
        checkOutput("reset dst_execute", 32'(dst_execute), 32'h0);
        checkOutput("reset dst_data", 32'(dst_data), 32'h0);
        checkOutput("reset iso_state", 32'(iso_state), 32'h0);
        checkOutput("reset iso_ack", 32'(iso_ack), 32'h0);
        checkOutput("reset drop_cnt", 32'(drop_cnt), 32'h0);

        step();
        arst_n = 1'b1;
        prime_queue();
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("post-reset %0d", i), 1'b0, 2'b11, 16'hA55A, 1'b0);
        end

        // Main vector table: latency, isolation entry, resume, resume abort.
        for (int i = 0; i < 30; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].iso, vecs[i].rdy, vecs[i].dat, vecs[i].gated);
            checkOutput($sformatf("vec%0d iso_state", i), 32'(iso_state), 32'(vecs[i].st));
            checkOutput($sformatf("vec%0d iso_ack", i), 32'(iso_ack), (vecs[i].st == 2'd2) ? 32'h1 : 32'h0);
        end

        // Reset in the second drain cycle must clear everything before the next edge.
        applyStimulus("drain0", 1'b1, 2'b01, 16'h0055, 1'b1);
        checkOutput("drain0 iso_state", 32'(iso_state), 32'h1);
        applyStimulus("drain1", 1'b1, 2'b01, 16'h0056, 1'b1);
        checkOutput("drain1 iso_state", 32'(iso_state), 32'h1);
        #2;
        arst_n = 1'b0;
        #1;
        checkOutput("async rst dst_execute", 32'(dst_execute), 32'h0);
        checkOutput("async rst dst_data", 32'(dst_data), 32'h0);
        checkOutput("async rst iso_state", 32'(iso_state), 32'h0);
        checkOutput("async rst iso_ack", 32'(iso_ack), 32'h0);
        checkOutput("async rst drop_cnt", 32'(drop_cnt), 32'h0);
        step();
        arst_n   = 1'b1;
        exp_drop = '0;
        prime_queue();
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("recover %0d", i), 1'b0, 2'b10, 16'h7700, 1'b0);
            checkOutput($sformatf("recover %0d iso_state", i), 32'(iso_state), 32'h0);
        end

        // Saturation of the drop counter under a long isolation with a continuous strobe.
        isolate   = 1'b1;
        src_ready = 2'b01;
        src_data  = 16'h00FF;
        repeat (65534) step();
        checkOutput("sat drop_cnt FFFE", 32'(drop_cnt), 32'h0000FFFE);
        checkOutput("sat iso_state", 32'(iso_state), 32'h2);
        checkOutput("sat dst_execute", 32'(dst_execute), 32'h0);
        step();
        checkOutput("sat drop_cnt FFFF", 32'(drop_cnt), 32'h0000FFFF);
        repeat (5) step();
        checkOutput("sat drop_cnt hold", 32'(drop_cnt), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
